// File: rtl/trace_readout_pkg.sv
// Shared constants, FSM state type and sizing helper for the trace readout block.
package trace_readout_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] TRL_BYTE = 8'h5A;

    localparam int FPAY           = 32;
    localparam int BYTES_PER_WORD = FPAY / 8;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        RD,
        CAP,
        SEND,
        CHK,
        TRL0,
        TRL1,
        TRL2
    } state_e;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/trace_readout_if.sv
// Byte stream toward the debug host link (valid/ready handshake).
interface trace_readout_if;

    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_out,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/trace_readout_word_serializer.sv
// Loads one trace word and emits its bytes LSB first under valid/ready.
module trace_word_serializer
    import trace_readout_pkg::*;
#(
    parameter int Fpay = FPAY
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [Fpay-1:0] word_in,
    input  logic            byte_ready,
    output logic [7:0]      byte_data,
    output logic            byte_valid,
    output logic            last_byte_done
);

    localparam int BPW = bytes_per_word(Fpay);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [Fpay-1:0] shift_q, shift_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic            valid_q, valid_d;
    logic            hs;

    assign hs             = valid_q && byte_ready;
    assign last_byte_done = hs && (remain_q == '0);
    assign byte_data      = shift_q[7:0];
    assign byte_valid     = valid_q;

    // Next-state: load a word, then shift one byte out per handshake until the count hits zero.
    always_comb begin
        shift_d  = shift_q;
        remain_d = remain_q;
        valid_d  = valid_q;
        if (load) begin
            shift_d  = word_in;
            remain_d = CW'(BPW - 1);
            valid_d  = 1'b1;
        end else if (hs) begin
            if (remain_q == '0) begin
                valid_d = 1'b0;
            end else begin
                shift_d  = shift_q >> 8;
                remain_d = remain_q - CW'(1);
            end
        end
    end

    // Serializer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            remain_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            remain_q <= remain_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/trace_readout.sv
// Trace buffer read-side controller: drains words on a dump request and frames
// them as A5 <data bytes> [checksum] 5A <count lo> <count hi> toward the host link.
// Optional checksum byte enabled by defining TRACE_READOUT_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for dump_start
// HDR   | presenting header byte A5
// RD    | tb_rd strobe to the trace buffer
// CAP   | tb_dout valid, loaded into the serializer
// SEND  | serializer emitting the word's bytes
// CHK   | presenting XOR of all data bytes (checksum build only)
// TRL0  | presenting trailer byte 5A
// TRL1  | presenting words_sent[7:0]
// TRL2  | presenting words_sent[15:8]
module trace_readout
    import trace_readout_pkg::*;
#(
    parameter int Fpay     = FPAY,
    parameter int TB_Depth = 512,
    parameter int CNTw     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              tb_empty,
    output logic              tb_rd,
    input  logic [Fpay-1:0]   tb_dout,
    output logic              busy,
    output logic [CNTw-1:0]   words_sent,
    trace_readout_if.master   host
);

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            tb_rd_q, tb_rd_d;
    logic [CNTw-1:0] ws_q, ws_d;
    logic [7:0]      frame_byte_q, frame_byte_d;
    logic            frame_valid_q, frame_valid_d;

    logic            ser_load;
    logic            ser_valid;
    logic            ser_last;
    logic [7:0]      ser_byte;

    logic            byte_valid_w;
    logic            hs;
    logic            more_words;
    logic            word_boundary;
    logic [15:0]     ws_ext;

`ifdef TRACE_READOUT_CHECKSUM_EN
    logic [7:0]      chk_q, chk_d;
`endif

    trace_word_serializer #(.Fpay(Fpay)) u_ser (
        .clk            (clk),
        .reset          (reset),
        .load           (ser_load),
        .word_in        (tb_dout),
        .byte_ready     (host.byte_ready),
        .byte_data      (ser_byte),
        .byte_valid     (ser_valid),
        .last_byte_done (ser_last)
    );

    // Frame bytes and data bytes are never valid together, so a plain mux suffices.
    assign byte_valid_w    = frame_valid_q | ser_valid;
    assign host.byte_valid = byte_valid_w;
    assign host.byte_out   = ser_valid ? ser_byte : frame_byte_q;
    assign hs              = byte_valid_w && host.byte_ready;

    assign tb_rd      = tb_rd_q;
    assign busy       = busy_q;
    assign words_sent = ws_q;

    // The empty flag is only looked at here, at the end of the header or of a word.
    assign more_words    = !tb_empty && (ws_q != CNTw'(TB_Depth));
    assign word_boundary = ((state_q == HDR) && hs) || ((state_q == SEND) && ser_last);
    assign ws_ext        = 16'(ws_q);

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        tb_rd_d       = 1'b0;
        ws_d          = ws_q;
        frame_byte_d  = frame_byte_q;
        frame_valid_d = frame_valid_q;
        ser_load      = 1'b0;
`ifdef TRACE_READOUT_CHECKSUM_EN
        chk_d = chk_q;
        if ((state_q == SEND) && ser_valid && host.byte_ready) begin
            chk_d = chk_q ^ ser_byte;
        end
`endif

        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    ws_d          = '0;
                    busy_d        = 1'b1;
                    frame_byte_d  = HDR_BYTE;
                    frame_valid_d = 1'b1;
                    state_d       = HDR;
`ifdef TRACE_READOUT_CHECKSUM_EN
                    chk_d = '0;
`endif
                end
            end
            HDR:  ;
            RD:   state_d = CAP;
            CAP: begin
                ser_load = 1'b1;
                if (ws_q != CNTw'(TB_Depth)) begin
                    ws_d = ws_q + CNTw'(1);
                end
                state_d = SEND;
            end
            SEND: ;
`ifdef TRACE_READOUT_CHECKSUM_EN
            CHK: begin
                if (hs) begin
                    frame_byte_d = TRL_BYTE;
                    state_d      = TRL0;
                end
            end
`endif
            TRL0: begin
                if (hs) begin
                    frame_byte_d = ws_ext[7:0];
                    state_d      = TRL1;
                end
            end
            TRL1: begin
                if (hs) begin
                    frame_byte_d = ws_ext[15:8];
                    state_d      = TRL2;
                end
            end
            TRL2: begin
                if (hs) begin
                    frame_valid_d = 1'b0;
                    busy_d        = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared empty/limit decision after the header and after each word.
        if (word_boundary) begin
            if (more_words) begin
                frame_valid_d = 1'b0;
                tb_rd_d       = 1'b1;
                state_d       = RD;
            end else begin
                frame_valid_d = 1'b1;
`ifdef TRACE_READOUT_CHECKSUM_EN
                frame_byte_d  = chk_d;
                state_d       = CHK;
`else
                frame_byte_d  = TRL_BYTE;
                state_d       = TRL0;
`endif
            end
        end
    end

    // FSM state and registered outputs; reset aborts any dump in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            tb_rd_q       <= 1'b0;
            ws_q          <= '0;
            frame_byte_q  <= '0;
            frame_valid_q <= 1'b0;
`ifdef TRACE_READOUT_CHECKSUM_EN
            chk_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            tb_rd_q       <= tb_rd_d;
            ws_q          <= ws_d;
            frame_byte_q  <= frame_byte_d;
            frame_valid_q <= frame_valid_d;
`ifdef TRACE_READOUT_CHECKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

endmodule
